// File: rtl/cpu_dma_tx_queue.sv
// cpu_dma_tx_queue: strips module headers from user-data-path packets, buffers whole packets and
// replays each to the DMA engine as a byte-length word followed by byte-swapped data words.
module cpu_dma_tx_queue #(
  parameter int DATA_WIDTH          = 32,
  parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int DMA_DATA_WIDTH      = 32,
  parameter int DMA_CTRL_WIDTH      = DMA_DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS     = 10,
  parameter int LEN_FIFO_DEPTH_BITS = 3,
  parameter int MAX_PKT_SIZE        = 2048
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  output logic                      cpu_q_dma_pkt_avail,
  input  logic                      cpu_q_dma_rd,
  output logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
  output logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
  input  logic                      tx_queue_en,
  output logic                      tx_pkt_stored,
  output logic                      tx_pkt_dropped,
  output logic                      tx_pkt_removed,
  output logic                      tx_q_underrun,
  output logic                      tx_q_overrun,
  output logic [11:0]               tx_pkt_byte_cnt,
  output logic [9:0]                tx_pkt_word_cnt
);
  localparam int MAX_PKT_WORDS = MAX_PKT_SIZE / 4;
  localparam int DEPTH         = 1 << FIFO_DEPTH_BITS;
  localparam int LDEPTH        = 1 << LEN_FIFO_DEPTH_BITS;
  localparam int PW            = FIFO_DEPTH_BITS;
  localparam int LW            = LEN_FIFO_DEPTH_BITS;

  typedef enum logic [1:0] {IN_HDR, IN_DATA, IN_DROP} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_DATA} out_state_t;

  in_state_t  r_in_state, w_in_next;
  out_state_t r_out_state, w_out_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [11:0]           r_len_mem [LDEPTH];
  logic [PW-1:0]         r_wr_ptr, r_commit_ptr, r_rd_ptr, w_wr_ptr_n, w_rd_ptr_n;
  logic [PW:0]           w_free_n;
  logic [LW:0]           r_len_wp, r_len_rp, w_len_cnt, w_len_cnt_n;
  logic [9:0]            r_wcnt, r_words_left;
  logic [1:0]            r_last_lo;
  logic [11:0]           r_byte_cnt, w_bytes, w_len_head;
  logic [9:0]            r_word_cnt;
  logic [2:0]            w_lanes;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic r_in_rdy, r_stored, r_dropped, r_removed, r_underrun, r_overrun;
  logic w_accept, w_last, w_oversize, w_write, w_commit, w_drop;
  logic w_len_empty, w_avail, w_pop, w_rd_word, w_final_rd;

  assign w_accept   = in_wr & r_in_rdy;
  assign w_last     = in_ctrl != '0;
  assign w_oversize = w_accept & (r_in_state == IN_DATA) & (r_wcnt == 10'(MAX_PKT_WORDS));
  assign w_write    = w_accept & ((r_in_state == IN_HDR & !w_last) | (r_in_state == IN_DATA & !w_oversize));
  assign w_commit   = w_accept & (r_in_state == IN_DATA) & w_last & !w_oversize;
  assign w_drop     = w_accept & w_last & ((r_in_state == IN_DROP) | w_oversize);
  assign w_lanes    = (in_ctrl == CTRL_WIDTH'(8)) ? 3'd1 : (in_ctrl == CTRL_WIDTH'(4)) ? 3'd2 :
                      (in_ctrl == CTRL_WIDTH'(2)) ? 3'd3 : 3'd4;
  assign w_bytes    = {r_wcnt, 2'b00} + {9'b0, w_lanes};

  assign w_len_cnt   = r_len_wp - r_len_rp;
  assign w_len_empty = w_len_cnt == '0;
  assign w_len_head  = r_len_mem[r_len_rp[LW-1:0]];
  assign w_avail     = !w_len_empty & tx_queue_en;
  assign w_pop       = (r_out_state == OUT_IDLE) & cpu_q_dma_rd & w_avail;
  assign w_rd_word   = (r_out_state == OUT_DATA) & cpu_q_dma_rd;
  assign w_final_rd  = w_rd_word & (r_words_left == 10'd1);

  // Readiness is judged on next-cycle state so a packet can only start with room for a maximal one.
  assign w_wr_ptr_n  = w_oversize ? r_commit_ptr : w_write ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_rd_ptr_n  = w_rd_word ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_free_n    = (PW+1)'(DEPTH) - {1'b0, w_wr_ptr_n - w_rd_ptr_n};
  assign w_len_cnt_n = w_len_cnt + (LW+1)'(w_commit) - (LW+1)'(w_pop);

  always_comb begin
    w_in_next = r_in_state;
    if (w_accept)
      w_in_next = (r_in_state == IN_HDR) ? (w_last ? IN_HDR : IN_DATA) :
                  w_last ? IN_HDR : w_oversize ? IN_DROP : r_in_state;
  end

  always_comb begin
    w_out_next = r_out_state;
    if (r_out_state == OUT_IDLE)
      w_out_next = w_pop ? OUT_DATA : OUT_IDLE;
    else
      w_out_next = w_final_rd ? OUT_IDLE : OUT_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_state  <= IN_HDR;
      r_out_state <= OUT_IDLE;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= in_data;
    if (w_commit) r_len_mem[r_len_wp[LW-1:0]] <= w_bytes;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_len_wp     <= '0;
      r_len_rp     <= '0;
      r_wcnt       <= '0;
      r_words_left <= '0;
      r_last_lo    <= '0;
      r_byte_cnt   <= '0;
      r_word_cnt   <= '0;
      r_in_rdy     <= 1'b0;
      r_stored     <= 1'b0;
      r_dropped    <= 1'b0;
      r_removed    <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_n;
      r_rd_ptr   <= w_rd_ptr_n;
      r_wcnt     <= (w_write & r_in_state == IN_HDR) ? 10'd1 : w_write ? r_wcnt + 10'd1 : r_wcnt;
      r_in_rdy   <= (w_in_next != IN_HDR) |
                    (tx_queue_en & (w_free_n >= (PW+1)'(MAX_PKT_WORDS + 2)) & (w_len_cnt_n != (LW+1)'(LDEPTH)));
      r_stored   <= w_commit;
      r_dropped  <= w_drop;
      r_removed  <= w_final_rd;
      r_underrun <= (r_out_state == OUT_IDLE) & cpu_q_dma_rd & !w_avail;
      r_overrun  <= in_wr & !r_in_rdy;
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + 1'b1;
        r_len_wp     <= r_len_wp + 1'b1;
        r_byte_cnt   <= w_bytes;
        r_word_cnt   <= r_wcnt + 10'd1;
      end
      if (w_pop) begin
        r_len_rp     <= r_len_rp + 1'b1;
        r_words_left <= 10'((w_len_head + 12'd3) >> 2);
        r_last_lo    <= w_len_head[1:0];
      end else if (w_rd_word)
        r_words_left <= r_words_left - 10'd1;
    end
  end

  assign w_mem_rd            = r_mem[r_rd_ptr];
  assign in_rdy              = r_in_rdy;
  assign cpu_q_dma_pkt_avail = w_avail;
  assign cpu_q_dma_rd_data   = (r_out_state == OUT_DATA) ?
                               {w_mem_rd[7:0], w_mem_rd[15:8], w_mem_rd[23:16], w_mem_rd[31:24]} :
                               w_len_empty ? '0 : {{(DMA_DATA_WIDTH-12){1'b0}}, w_len_head};
  // Length mod 4 selects the final lane: 0 -> 'h8, 1 -> 'h1, 2 -> 'h2, 3 -> 'h4.
  assign cpu_q_dma_rd_ctrl   = (r_out_state == OUT_DATA && r_words_left == 10'd1) ?
                               DMA_CTRL_WIDTH'(4'b0001 << (r_last_lo - 2'd1)) : '0;
  assign tx_pkt_stored       = r_stored;
  assign tx_pkt_dropped      = r_dropped;
  assign tx_pkt_removed      = r_removed;
  assign tx_q_underrun       = r_underrun;
  assign tx_q_overrun        = r_overrun;
  assign tx_pkt_byte_cnt     = r_byte_cnt;
  assign tx_pkt_word_cnt     = r_word_cnt;
endmodule
